// File: rtl/game_pkg.sv
// Shared types for the game flow controller.
// State and screen codes plus a width helper.
package game_pkg;

  typedef enum logic [2:0] {
    TITLE,
    LOAD,
    PLAY,
    WIN_BANNER,
    LOSE_BANNER,
    VICTORY,
    GAME_OVER
  } state_t;

  typedef enum logic [2:0] {
    SCR_TITLE    = 3'd0,
    SCR_LEVEL    = 3'd1,
    SCR_WIN      = 3'd2,
    SCR_LOSE     = 3'd3,
    SCR_VICTORY  = 3'd4,
    SCR_GAMEOVER = 3'd5
  } screen_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_sequencer_button_pulse.sv
// Push-button synchronizer with rising-edge pulse.
// History presets to "pressed" so a press held through reset is ignored.
module button_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d  = {sync_q[1:0], btn_i};
  assign pulse_o = sync_q[1] & ~sync_q[2];

  // two-flop synchronizer plus one flop of edge history
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 3'b111;
    else       sync_q <= sync_d;
  end

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: title, levels, banners, lives.
// Owns level resets and the screen code for the RGB mux.
module game_sequencer
  import game_pkg::*;
#(
  parameter  int NUM_LEVELS    = 3,
  parameter  int LIVES         = 3,
  parameter  int SETTLE_CYCLES = 4,
  parameter  int BANNER_FRAMES = 120,
  localparam int LW            = clog2_min1(NUM_LEVELS)
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic                  start_button,
  input  logic                  frame_tick,
  input  logic [NUM_LEVELS-1:0] level_win,
  input  logic [NUM_LEVELS-1:0] level_lose,
  output logic [NUM_LEVELS-1:0] level_reset_n,
  output logic [LW-1:0]         active_level,
  output logic [2:0]            screen,
  output logic [1:0]            lives
);

  localparam int CW = 16;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] BANNER_LAST = CW'(BANNER_FRAMES - 1);
  localparam logic [LW-1:0] LAST_LVL    = LW'(NUM_LEVELS - 1);
  localparam logic [1:0]    START_LIVES = 2'(LIVES);

  state_t                  state_q, state_d;
  logic [LW-1:0]           lvl_q, lvl_d;
  logic [1:0]              lives_q, lives_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_LEVELS-1:0]   rstn_q, rstn_d;
  logic                    start_pulse;
  logic                    win_s, lose_s;
  screen_t                 scr;

  button_pulse u_start (
    .clk_i   (vga_clock),
    .rst_i   (reset),
    .btn_i   (start_button),
    .pulse_o (start_pulse)
  );

  assign win_s  = level_win[lvl_q];
  assign lose_s = level_lose[lvl_q];

  // next-state, level, lives and shared settle/banner counter
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    case (state_q)
      TITLE: begin
        if (start_pulse) begin
          state_d = LOAD;
          lvl_d   = '0;
          lives_d = START_LIVES;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = PLAY;
          cnt_d   = '0;
        end
      end
      PLAY: begin
        if (win_s) begin
          state_d = WIN_BANNER;
          cnt_d   = '0;
        end else if (lose_s) begin
          state_d = LOSE_BANNER;
          lives_d = lives_q - 2'd1;
          cnt_d   = '0;
        end
      end
      WIN_BANNER: begin
        if (frame_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BANNER_LAST) begin
            cnt_d = '0;
            if (lvl_q == LAST_LVL) begin
              state_d = VICTORY;
            end else begin
              lvl_d   = lvl_q + 1'b1;
              state_d = LOAD;
            end
          end
        end
      end
      LOSE_BANNER: begin
        if (frame_tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BANNER_LAST) begin
            cnt_d = '0;
            if (lives_q == 2'd0) state_d = GAME_OVER;
            else                 state_d = LOAD;
          end
        end
      end
      VICTORY, GAME_OVER: begin
        if (start_pulse) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
  end

  // only the live level leaves reset, aligned with the PLAY state
  always_comb begin
    rstn_d = '0;
    if (state_d == PLAY) rstn_d[lvl_d] = 1'b1;
  end

  // screen code seen by the RGB mux
  always_comb begin
    scr = SCR_TITLE;
    case (state_q)
      TITLE:       scr = SCR_TITLE;
      LOAD, PLAY:  scr = SCR_LEVEL;
      WIN_BANNER:  scr = SCR_WIN;
      LOSE_BANNER: scr = SCR_LOSE;
      VICTORY:     scr = SCR_VICTORY;
      GAME_OVER:   scr = SCR_GAMEOVER;
      default:     scr = SCR_TITLE;
    endcase
  end

  // state registers
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q <= TITLE;
      lvl_q   <= '0;
      lives_q <= START_LIVES;
      cnt_q   <= '0;
      rstn_q  <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
    end
  end

  assign level_reset_n = rstn_q;
  assign active_level  = lvl_q;
  assign screen        = scr;
  assign lives         = lives_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized scoreboard bench for game_sequencer.
// A game-rule model predicts outputs; a monitor compares them.
module tb_game_sequencer;

  localparam int NL = 3;
  localparam int LV = 3;
  localparam int SC = 4;
  localparam int BF = 2;
  localparam int NCYC = 20000;

  localparam int M_TITLE = 0;
  localparam int M_LOAD  = 1;
  localparam int M_PLAY  = 2;
  localparam int M_WINB  = 3;
  localparam int M_LOSEB = 4;
  localparam int M_VIC   = 5;
  localparam int M_GO    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_button;
  logic          frame_tick;
  logic [NL-1:0] level_win;
  logic [NL-1:0] level_lose;
  logic [NL-1:0] level_reset_n;
  logic [1:0]    active_level;
  logic [2:0]    screen;
  logic [1:0]    lives;

  always #5 clk = ~clk;

  game_sequencer #(
    .NUM_LEVELS    (NL),
    .LIVES         (LV),
    .SETTLE_CYCLES (SC),
    .BANNER_FRAMES (BF)
  ) dut (
    .vga_clock     (clk),
    .reset         (reset),
    .start_button  (start_button),
    .frame_tick    (frame_tick),
    .level_win     (level_win),
    .level_lose    (level_lose),
    .level_reset_n (level_reset_n),
    .active_level  (active_level),
    .screen        (screen),
    .lives         (lives)
  );

  typedef struct packed {
    logic [2:0] scr;
    logic [1:0] lvl;
    logic [1:0] lv;
    logic [2:0] rn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_st = M_TITLE;
  int m_lvl = 0;
  int m_lives = LV;
  int m_cnt = 0;
  bit b1 = 1, b2 = 1, b3 = 1;

  int cov_vic = 0, cov_go = 0, cov_both = 0, cov_rlose = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int scr_of(input int st);
    case (st)
      M_TITLE:         return 0;
      M_LOAD, M_PLAY:  return 1;
      M_WINB:          return 2;
      M_LOSEB:         return 3;
      M_VIC:           return 4;
      default:         return 5;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit btn, input bit tick,
                            input logic [NL-1:0] w, input logic [NL-1:0] l);
    bit pulse;
    if (rst) begin
      if (m_st == M_LOSEB && m_lives == 1) cov_rlose++;
      m_st = M_TITLE; m_lvl = 0; m_lives = LV; m_cnt = 0;
      b1 = 1; b2 = 1; b3 = 1;
      return;
    end
    pulse = b2 && !b3;
    b3 = b2; b2 = b1; b1 = btn;
    case (m_st)
      M_TITLE: if (pulse) begin
        m_st = M_LOAD; m_lvl = 0; m_lives = LV; m_cnt = 0;
      end
      M_LOAD: begin
        m_cnt++;
        if (m_cnt == SC) m_st = M_PLAY;
      end
      M_PLAY: begin
        if (w[m_lvl]) begin
          if (l[m_lvl]) cov_both++;
          m_st = M_WINB; m_cnt = 0;
        end else if (l[m_lvl]) begin
          m_st = M_LOSEB; m_lives--; m_cnt = 0;
        end
      end
      M_WINB: if (tick) begin
        m_cnt++;
        if (m_cnt == BF) begin
          m_cnt = 0;
          if (m_lvl == NL - 1) begin
            m_st = M_VIC; cov_vic++;
          end else begin
            m_lvl++; m_st = M_LOAD;
          end
        end
      end
      M_LOSEB: if (tick) begin
        m_cnt++;
        if (m_cnt == BF) begin
          m_cnt = 0;
          if (m_lives == 0) begin
            m_st = M_GO; cov_go++;
          end else begin
            m_st = M_LOAD;
          end
        end
      end
      default: if (pulse) m_st = M_TITLE;
    endcase
  endtask

  // monitor: pops one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("screen", int'(screen), int'(e.scr));
        check("active_level", int'(active_level), int'(e.lvl));
        check("lives", int'(lives), int'(e.lv));
        check("level_reset_n", int'(level_reset_n), int'(e.rn));
      end
    end
  end

  // driver: random stimulus, model prediction pushed per edge
  initial begin
    bit held = 0;
    bit rdir_done = 0;
    exp_t e;
    reset = 1'b1; start_button = 1'b0; frame_tick = 1'b0;
    level_win = '0; level_lose = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c >= 23 && $urandom_range(0, 5) == 0) held = ~held;
      reset = (c < 3) || ($urandom_range(0, 799) == 0);
      if (!rdir_done && m_st == M_LOSEB && m_lives == 1) begin
        reset = 1'b1; rdir_done = 1;
      end
      start_button = held;
      frame_tick = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NL; i++) begin
        level_win[i]  = ($urandom_range(0, 7) == 0);
        level_lose[i] = ($urandom_range(0, 9) == 0);
      end
      model_step(reset, start_button, frame_tick, level_win, level_lose);
      e.scr = 3'(scr_of(m_st));
      e.lvl = 2'(m_lvl);
      e.lv  = 2'(m_lives);
      e.rn  = (m_st == M_PLAY) ? 3'(1 << m_lvl) : 3'd0;
      q.push_back(e);
    end
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    check("victory_reached", int'(cov_vic > 0), 1);
    check("gameover_reached", int'(cov_go > 0), 1);
    check("win_lose_same_cycle", int'(cov_both > 0), 1);
    check("reset_in_lose_banner", int'(cov_rlose > 0), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
